// File: rtl/adder_pipe_nbit_if.sv
// Operand/result handshake bundle for adder_pipe_nbit; the DUT takes the slave modport.
// The ovf member and its modport entries exist only when ADDER_OVF_EN is defined.
interface adder_pipe_nbit_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] S;
    logic             Cout;
`ifdef ADDER_OVF_EN
    logic             ovf;

    modport master (
        output in_valid, A, B, Cin, sub, out_ready,
        input  in_ready, out_valid, S, Cout, ovf
    );
    modport slave (
        input  in_valid, A, B, Cin, sub, out_ready,
        output in_ready, out_valid, S, Cout, ovf
    );
`else
    modport master (
        output in_valid, A, B, Cin, sub, out_ready,
        input  in_ready, out_valid, S, Cout
    );
    modport slave (
        input  in_valid, A, B, Cin, sub, out_ready,
        output in_ready, out_valid, S, Cout
    );
`endif
endinterface

// File: rtl/adder_pipe_nbit.sv
// Pipelined N-bit adder/subtractor: carry chain cut into CHUNK-bit slices, one register stage per slice.
// Optional signed-overflow output is enabled by defining ADDER_OVF_EN.
module adder_pipe_nbit #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    adder_pipe_nbit_if.slave  bus
);
    localparam int unsigned STAGES = WIDTH / CHUNK;

    if (WIDTH % CHUNK != 0) begin : g_bad_width
        $error("adder_pipe_nbit: WIDTH must be a multiple of CHUNK");
    end

    logic             advance;
    logic [WIDTH-1:0] b_eff;
    logic             c0;

    // Whole pipe moves together; it only stalls while a finished result waits.
    assign advance      = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = advance;
    assign b_eff        = bus.sub ? ~bus.B : bus.B;
    assign c0           = bus.sub ? 1'b1 : bus.Cin;

    for (genvar k = 0; k < STAGES; k++) begin : st
        logic [CHUNK-1:0]       a_sl;
        logic [CHUNK-1:0]       b_sl;
        logic                   c_in;
        logic                   v_in;
        logic [CHUNK:0]         sum;
        logic [(k+1)*CHUNK-1:0] res_nx;
        logic                   vld_q;
        logic                   c_q;
        logic [(k+1)*CHUNK-1:0] res_q;

        // Operands shrink by one slice per stage; the result grows by one slice.
        if (k == 0) begin : g_src
            assign a_sl   = bus.A[CHUNK-1:0];
            assign b_sl   = b_eff[CHUNK-1:0];
            assign c_in   = c0;
            assign v_in   = bus.in_valid;
            assign res_nx = sum[CHUNK-1:0];
        end else begin : g_src
            assign a_sl   = st[k-1].g_fwd.a_q[CHUNK-1:0];
            assign b_sl   = st[k-1].g_fwd.b_q[CHUNK-1:0];
            assign c_in   = st[k-1].c_q;
            assign v_in   = st[k-1].vld_q;
            assign res_nx = {sum[CHUNK-1:0], st[k-1].res_q};
        end

        assign sum = {1'b0, a_sl} + {1'b0, b_sl} + {{CHUNK{1'b0}}, c_in};

        // Data regs load only for valid ops, so idle-bus junk never lands in S.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q <= 1'b0;
                c_q   <= 1'b0;
                res_q <= '0;
            end else if (advance) begin
                vld_q <= v_in;
                if (v_in) begin
                    c_q   <= sum[CHUNK];
                    res_q <= res_nx;
                end
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            localparam int unsigned REM = WIDTH - (k + 1) * CHUNK;
            logic [REM-1:0] a_nx;
            logic [REM-1:0] b_nx;
            logic [REM-1:0] a_q;
            logic [REM-1:0] b_q;

            if (k == 0) begin : g_nx
                assign a_nx = bus.A[WIDTH-1:CHUNK];
                assign b_nx = b_eff[WIDTH-1:CHUNK];
            end else begin : g_nx
                assign a_nx = st[k-1].g_fwd.a_q[REM+CHUNK-1:CHUNK];
                assign b_nx = st[k-1].g_fwd.b_q[REM+CHUNK-1:CHUNK];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (advance && v_in) begin
                    a_q <= a_nx;
                    b_q <= b_nx;
                end
            end
        end

`ifdef ADDER_OVF_EN
        if (k == STAGES - 1) begin : g_ovf
            logic ovf_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else if (advance && v_in) begin
                    ovf_q <= (a_sl[CHUNK-1] == b_sl[CHUNK-1]) && (sum[CHUNK-1] != a_sl[CHUNK-1]);
                end
            end
        end
`endif
    end

    assign bus.out_valid = st[STAGES-1].vld_q;
    assign bus.S         = st[STAGES-1].res_q;
    assign bus.Cout      = st[STAGES-1].c_q;
`ifdef ADDER_OVF_EN
    assign bus.ovf       = st[STAGES-1].g_ovf.ovf_q;
`endif

endmodule
